// File: rtl/hazard_tracker.sv
// Pipeline hazard unit: tracks E/M/W destinations to produce D-stage stall
// and the D/E forwarding-mux selects.
module hazard_tracker #(
  parameter int unsigned TW       = 2,
  parameter logic [4:0]  ZERO_REG = 5'd0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    d_a1,
  input  logic [4:0]    d_a2,
  input  logic [4:0]    d_a3,
  input  logic          d_we,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [TW-1:0] d_tnew,
  output logic          stall,
  output logic [1:0]    fwd_rs_d,
  output logic [1:0]    fwd_rt_d,
  output logic [1:0]    fwd_rs_e,
  output logic [1:0]    fwd_rt_e
);

  localparam int unsigned RW = 5;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_E    = 2'd1;
  localparam logic [1:0] SEL_M    = 2'd2;
  localparam logic [1:0] SEL_W    = 2'd3;

  logic          e_we, m_we, w_we;
  logic [RW-1:0] e_a3, m_a3, w_a3;
  logic [TW-1:0] e_tnew, m_tnew, w_tnew;
  logic [RW-1:0] e_a1, e_a2;

  // Stage entry matches a source register; the zero register never matches.
  function automatic logic hit(input logic we, input logic [RW-1:0] a3,
                               input logic [RW-1:0] src);
    return we && (a3 == src) && (src != ZERO_REG);
  endfunction

  // Nearest producer wins even when it is not ready yet (no fallthrough).
  function automatic logic [1:0] sel_d(input logic [RW-1:0] src);
    logic [1:0] sel;
    sel = SEL_NONE;
    if (hit(e_we, e_a3, src))      sel = (e_tnew == '0) ? SEL_E : SEL_NONE;
    else if (hit(m_we, m_a3, src)) sel = (m_tnew == '0) ? SEL_M : SEL_NONE;
    else if (hit(w_we, w_a3, src)) sel = (w_tnew == '0) ? SEL_W : SEL_NONE;
    return sel;
  endfunction

  function automatic logic [1:0] sel_e(input logic [RW-1:0] src);
    logic [1:0] sel;
    sel = SEL_NONE;
    if (hit(m_we, m_a3, src))      sel = (m_tnew == '0) ? SEL_M : SEL_NONE;
    else if (hit(w_we, w_a3, src)) sel = (w_tnew == '0) ? SEL_W : SEL_NONE;
    return sel;
  endfunction

  always_comb begin
    stall    = 1'b0;
    fwd_rs_d = SEL_NONE;
    fwd_rt_d = SEL_NONE;
    fwd_rs_e = SEL_NONE;
    fwd_rt_e = SEL_NONE;
    // W always has its result, so only E and M can force a stall.
    if (hit(e_we, e_a3, d_a1) && (e_tnew > d_tuse_rs)) stall = 1'b1;
    if (hit(m_we, m_a3, d_a1) && (m_tnew > d_tuse_rs)) stall = 1'b1;
    if (hit(e_we, e_a3, d_a2) && (e_tnew > d_tuse_rt)) stall = 1'b1;
    if (hit(m_we, m_a3, d_a2) && (m_tnew > d_tuse_rt)) stall = 1'b1;
    fwd_rs_d = sel_d(d_a1);
    fwd_rt_d = sel_d(d_a2);
    fwd_rs_e = sel_e(e_a1);
    fwd_rt_e = sel_e(e_a2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_we   <= 1'b0;
      e_a3   <= '0;
      e_tnew <= '0;
      e_a1   <= '0;
      e_a2   <= '0;
      m_we   <= 1'b0;
      m_a3   <= '0;
      m_tnew <= '0;
      w_we   <= 1'b0;
      w_a3   <= '0;
      w_tnew <= '0;
    end else begin
      w_we   <= m_we;
      w_a3   <= m_a3;
      w_tnew <= '0;
      m_we   <= e_we;
      m_a3   <= e_a3;
      m_tnew <= (e_tnew == '0) ? '0 : e_tnew - TW'(1);
      if (stall) begin
        e_we   <= 1'b0;
        e_a3   <= '0;
        e_tnew <= '0;
        e_a1   <= '0;
        e_a2   <= '0;
      end else begin
        e_we   <= d_we;
        e_a3   <= d_a3;
        e_tnew <= d_tnew;
        e_a1   <= d_a1;
        e_a2   <= d_a2;
      end
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: directed pipeline scenarios followed by random
// traffic, checked against an age-based model of in-flight instructions.
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_a1, d_a2, d_a3;
  logic       d_we;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       stall;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  int checks = 0;
  int errors = 0;

  hazard_tracker dut (
    .clk(clk), .reset(reset),
    .d_a1(d_a1), .d_a2(d_a2), .d_a3(d_a3), .d_we(d_we),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_tnew(d_tnew),
    .stall(stall),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e)
  );

  always #5 clk = ~clk;

  // Instruction that entered E; its age (queue index) gives the stage.
  typedef struct {
    bit       we;
    bit [4:0] a3;
    bit [4:0] a1;
    bit [4:0] a2;
    int       tnew;
  } ins_t;

  ins_t pipe[$];

  function automatic ins_t empty_ins();
    ins_t r;
    r.we = 0; r.a3 = 0; r.a1 = 0; r.a2 = 0; r.tnew = 0;
    return r;
  endfunction

  function automatic int remaining(input int age);
    int r;
    if (age >= 2) return 0;
    r = pipe[age].tnew - age;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic bit produces(input int age, input bit [4:0] s);
    return pipe[age].we && pipe[age].a3 == s && s != 5'd0;
  endfunction

  function automatic bit m_stall();
    bit st = 0;
    for (int age = 0; age < 2; age++) begin
      if (produces(age, d_a1) && remaining(age) > int'(d_tuse_rs)) st = 1;
      if (produces(age, d_a2) && remaining(age) > int'(d_tuse_rt)) st = 1;
    end
    return st;
  endfunction

  // Code for a producer at a given age is age+1 (E=1, M=2, W=3).
  function automatic bit [1:0] m_fwd(input bit [4:0] s, input int first_age);
    for (int age = first_age; age < 3; age++)
      if (produces(age, s)) return (remaining(age) == 0) ? 2'(age + 1) : 2'd0;
    return 2'd0;
  endfunction

  task automatic model_edge();
    ins_t r;
    if (reset) begin
      pipe = {};
      for (int i = 0; i < 3; i++) pipe.push_back(empty_ins());
    end else begin
      r = empty_ins();
      if (!m_stall()) begin
        r.we = d_we; r.a3 = d_a3; r.a1 = d_a1; r.a2 = d_a2; r.tnew = int'(d_tnew);
      end
      pipe.push_front(r);
      void'(pipe.pop_back());
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("stall_model", int'(stall), int'(m_stall()));
    check("fwd_rs_d_model", int'(fwd_rs_d), int'(m_fwd(d_a1, 0)));
    check("fwd_rt_d_model", int'(fwd_rt_d), int'(m_fwd(d_a2, 0)));
    check("fwd_rs_e_model", int'(fwd_rs_e), int'(m_fwd(pipe[0].a1, 1)));
    check("fwd_rt_e_model", int'(fwd_rt_e), int'(m_fwd(pipe[0].a2, 1)));
  endtask

  task automatic drive(input bit we, input bit [4:0] a3, input bit [1:0] tn,
                       input bit [4:0] a1, input bit [1:0] urs,
                       input bit [4:0] a2, input bit [1:0] urt);
    d_we = we; d_a3 = a3; d_tnew = tn;
    d_a1 = a1; d_tuse_rs = urs; d_a2 = a2; d_tuse_rt = urt;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 3, 0, 3);
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 3, 0, 3);
  endtask

  initial begin
    reset = 1'b1;
    nop();
    for (int i = 0; i < 3; i++) pipe.push_back(empty_ins());
    step();
    step();
    reset = 1'b0;
    #1;
    check("reset_stall", int'(stall), 0);
    check("reset_fwd_rs_e", int'(fwd_rs_e), 0);

    // Reset mid-stream with $5 in every stage.
    for (int i = 0; i < 3; i++) begin
      drive(1, 5, 0, 0, 3, 0, 3);
      step();
    end
    drive(0, 0, 0, 5, 0, 5, 0);
    check("pre_reset_fwd_rs_d", int'(fwd_rs_d), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(0, 0, 0, 5, 0, 5, 0);
    check("postrst_stall", int'(stall), 0);
    check("postrst_fwd_rs_d", int'(fwd_rs_d), 0);
    check("postrst_fwd_rt_d", int'(fwd_rt_d), 0);
    check("postrst_fwd_rs_e", int'(fwd_rs_e), 0);
    check("postrst_fwd_rt_e", int'(fwd_rt_e), 0);

    // Load-use on $8.
    do_reset();
    drive(1, 8, 2, 0, 3, 0, 3);
    step();
    drive(0, 0, 0, 8, 1, 0, 3);
    check("lu_stall", int'(stall), 1);
    step();
    check("lu_stall_clear", int'(stall), 0);
    check("lu_fwd_rs_d", int'(fwd_rs_d), 0);
    step();
    nop();
    check("lu_fwd_rs_e", int'(fwd_rs_e), 3);

    // ALU chain on $3.
    do_reset();
    drive(1, 3, 1, 0, 3, 0, 3);
    step();
    drive(0, 0, 0, 0, 3, 3, 1);
    check("alu_stall", int'(stall), 0);
    check("alu_fwd_rt_d", int'(fwd_rt_d), 0);
    step();
    nop();
    check("alu_fwd_rt_e", int'(fwd_rt_e), 2);

    // Branch consuming in D right after an ALU op on $4.
    do_reset();
    drive(1, 4, 1, 0, 3, 0, 3);
    step();
    drive(0, 0, 0, 4, 0, 0, 3);
    check("br_stall", int'(stall), 1);
    step();
    check("br_stall_clear", int'(stall), 0);
    check("br_fwd_rs_d", int'(fwd_rs_d), 2);

    // Younger unready $6 in E shadows ready $6 in M.
    do_reset();
    drive(1, 6, 1, 0, 3, 0, 3);
    step();
    drive(1, 6, 1, 0, 3, 0, 3);
    step();
    drive(0, 0, 0, 6, 2, 0, 3);
    check("sh_stall", int'(stall), 0);
    check("sh_fwd_rs_d", int'(fwd_rs_d), 0);
    step();
    nop();
    check("sh_fwd_rs_e", int'(fwd_rs_e), 2);

    // Writes to $0 never hazard.
    do_reset();
    drive(1, 0, 2, 0, 3, 0, 3);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("z_stall", int'(stall), 0);
    check("z_fwd_rs_d", int'(fwd_rs_d), 0);

    // Random traffic over a small register set to force collisions.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      check_model();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
